// File: rtl/key_debounce_ctrl.sv
// Push-button front end: per-key synchroniser, debouncer and short/long press
// classifier, plus the LED speed/pause controls driven by keys 0 and 1.
module key_debounce_ctrl #(
    parameter int N_KEYS       = 2,
    parameter int DEBOUNCE_CYC = 270_000,
    parameter int LONG_CYC     = 27_000_000,
    parameter int CNT_W        = 25
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_short,
    output logic [N_KEYS-1:0] key_long,
    output logic [1:0]        speed_sel,
    output logic              pause
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } key_state_e;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_key
            logic             sync_p0, sync_p1, pressed_s;
            logic             level_q;
            logic [CNT_W-1:0] db_cnt;
            logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
            key_state_e       state, state_nxt;
            logic             press_nxt, release_nxt, short_nxt, long_nxt;
            logic             press_q, release_q, short_q, long_q;

            // Synchroniser stages; idle value 1 means released
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    sync_p0 <= 1'b1;
                    sync_p1 <= 1'b1;
                end else begin
                    sync_p0 <= key_n[gi];
                    sync_p1 <= sync_p0;
                end
            end

            assign pressed_s = ~sync_p1;

            // Debounce: level follows only after DEBOUNCE_CYC consecutive disagreeing cycles
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    level_q <= 1'b0;
                    db_cnt  <= '0;
                end else if (pressed_s == level_q) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_LAST) begin
                    level_q <= pressed_s;
                    db_cnt  <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end

            // Release is tested before the terminal count so it wins on a tie
            always_comb begin
                state_nxt    = state;
                hold_cnt_nxt = hold_cnt;
                press_nxt    = 1'b0;
                release_nxt  = 1'b0;
                short_nxt    = 1'b0;
                long_nxt     = 1'b0;
                case (state)
                    IDLE: begin
                        if (level_q) begin
                            press_nxt    = 1'b1;
                            hold_cnt_nxt = '0;
                            state_nxt    = PRESSED;
                        end
                    end
                    PRESSED: begin
                        if (!level_q) begin
                            release_nxt = 1'b1;
                            short_nxt   = 1'b1;
                            state_nxt   = IDLE;
                        end else if (hold_cnt == LONG_LAST) begin
                            long_nxt  = 1'b1;
                            state_nxt = HELD;
                        end else begin
                            hold_cnt_nxt = hold_cnt + 1'b1;
                        end
                    end
                    HELD: begin
                        if (!level_q) begin
                            release_nxt = 1'b1;
                            state_nxt   = IDLE;
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end

            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    state     <= IDLE;
                    hold_cnt  <= '0;
                    press_q   <= 1'b0;
                    release_q <= 1'b0;
                    short_q   <= 1'b0;
                    long_q    <= 1'b0;
                end else begin
                    state     <= state_nxt;
                    hold_cnt  <= hold_cnt_nxt;
                    press_q   <= press_nxt;
                    release_q <= release_nxt;
                    short_q   <= short_nxt;
                    long_q    <= long_nxt;
                end
            end

            assign key_level[gi]   = level_q;
            assign key_press[gi]   = press_q;
            assign key_release[gi] = release_q;
            assign key_short[gi]   = short_q;
            assign key_long[gi]    = long_q;
        end
    endgenerate

    // Long press on key 1 restores defaults and outranks a same-cycle speed step
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            speed_sel <= 2'd0;
            pause     <= 1'b0;
        end else if (key_long[1]) begin
            speed_sel <= 2'd0;
            pause     <= 1'b0;
        end else begin
            if (key_short[0]) speed_sel <= speed_sel + 2'd1;
            if (key_short[1]) pause     <= ~pause;
        end
    end

endmodule

// File: tb/tb_key_debounce_ctrl.sv
// Directed bench for key_debounce_ctrl with short debounce/long-press constants.
module tb_key_debounce_ctrl;

    localparam int N_KEYS = 2;
    localparam int DB     = 8;
    localparam int LONG   = 64;
    localparam int CW     = 8;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n;
    logic [N_KEYS-1:0] key_n;
    logic [N_KEYS-1:0] key_level, key_press, key_release, key_short, key_long;
    logic [1:0]        speed_sel;
    logic              pause;

    key_debounce_ctrl #(
        .N_KEYS(N_KEYS), .DEBOUNCE_CYC(DB), .LONG_CYC(LONG), .CNT_W(CW)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_n(key_n),
        .key_level(key_level), .key_press(key_press), .key_release(key_release),
        .key_short(key_short), .key_long(key_long),
        .speed_sel(speed_sel), .pause(pause)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge
    int n_press[2] = '{0, 0};
    int n_rel[2]   = '{0, 0};
    int n_short[2] = '{0, 0};
    int n_long[2]  = '{0, 0};
    int n_rise[2]  = '{0, 0};
    int press_cyc[2] = '{0, 0};
    int rel_cyc[2]   = '{0, 0};
    int long_cyc[2]  = '{0, 0};
    logic [1:0] lvl_q = 2'b00;

    always @(negedge sys_clk) begin
        for (int k = 0; k < 2; k++) begin
            if (key_press[k])   begin n_press[k] <= n_press[k] + 1; press_cyc[k] <= cyc; end
            if (key_release[k]) begin n_rel[k]   <= n_rel[k] + 1;   rel_cyc[k]   <= cyc; end
            if (key_short[k])   n_short[k] <= n_short[k] + 1;
            if (key_long[k])    begin n_long[k]  <= n_long[k] + 1;  long_cyc[k]  <= cyc; end
            if (key_level[k] && !lvl_q[k]) n_rise[k] <= n_rise[k] + 1;
        end
        lvl_q <= key_level;
    end

    int b_press[2], b_rel[2], b_short[2], b_long[2], b_rise[2];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic snap();
        for (int k = 0; k < 2; k++) begin
            b_press[k] = n_press[k];
            b_rel[k]   = n_rel[k];
            b_short[k] = n_short[k];
            b_long[k]  = n_long[k];
            b_rise[k]  = n_rise[k];
        end
    endtask

    task automatic do_press(input int k, input int hold, output int edge_cyc);
        key_n[k] = 1'b0;
        edge_cyc = cyc;
        step(hold);
        key_n[k] = 1'b1;
        step(30);
    endtask

    task automatic bounce_press(input int k, input int hold);
        key_n[k] = 1'b0; step(3);
        key_n[k] = 1'b1; step(3);
        key_n[k] = 1'b0; step(3);
        key_n[k] = 1'b1; step(3);
        key_n[k] = 1'b0; step(hold);
        key_n[k] = 1'b1; step(3);
        key_n[k] = 1'b0; step(3);
        key_n[k] = 1'b1; step(3);
        key_n[k] = 1'b0; step(3);
        key_n[k] = 1'b1; step(30);
    endtask

    initial begin
        int e;
        int r;
        int lat;
        bit found;

        sys_rst_n = 1'b0;
        key_n     = 2'b11;
        step(3);
        chk("rst_level", int'(key_level), 0);
        chk("rst_press", int'(key_press), 0);
        chk("rst_release", int'(key_release), 0);
        chk("rst_short", int'(key_short), 0);
        chk("rst_long", int'(key_long), 0);
        chk("rst_speed", int'(speed_sel), 0);
        chk("rst_pause", int'(pause), 0);
        sys_rst_n = 1'b1;
        step(2);

        // Glitch shorter than the debounce window
        snap();
        key_n[0] = 1'b0; step(5);
        key_n[0] = 1'b1; step(30);
        chk("glitch_rise", n_rise[0] - b_rise[0], 0);
        chk("glitch_press", n_press[0] - b_press[0], 0);
        chk("glitch_level", int'(key_level[0]), 0);

        // Four short presses on key 0 cycle the speed select
        for (int i = 0; i < 4; i++) begin
            snap();
            do_press(0, 30, e);
            chk("short_press_lat", press_cyc[0] - e, 11);
            chk("short_rel_lat", rel_cyc[0] - (e + 30), 11);
            chk("short_cnt", n_short[0] - b_short[0], 1);
            chk("short_long_cnt", n_long[0] - b_long[0], 0);
            chk("short_speed", int'(speed_sel), (i + 1) % 4);
        end

        // Set speed and pause, then a long press on key 1 restores defaults
        do_press(0, 30, e);
        do_press(1, 30, e);
        chk("pre_long_speed", int'(speed_sel), 1);
        chk("pre_long_pause", int'(pause), 1);
        snap();
        do_press(1, 100, e);
        chk("long_cnt", n_long[1] - b_long[1], 1);
        chk("long_lat", long_cyc[1] - press_cyc[1], 64);
        chk("long_short_cnt", n_short[1] - b_short[1], 0);
        chk("long_rel_cnt", n_rel[1] - b_rel[1], 1);
        chk("long_speed", int'(speed_sel), 0);
        chk("long_pause", int'(pause), 0);

        // Bouncy short presses on key 1 toggle pause once each
        snap();
        bounce_press(1, 40);
        chk("bounce1_press", n_press[1] - b_press[1], 1);
        chk("bounce1_rel", n_rel[1] - b_rel[1], 1);
        chk("bounce1_short", n_short[1] - b_short[1], 1);
        chk("bounce1_pause", int'(pause), 1);
        snap();
        bounce_press(1, 40);
        chk("bounce2_press", n_press[1] - b_press[1], 1);
        chk("bounce2_rise", n_rise[1] - b_rise[1], 1);
        chk("bounce2_pause", int'(pause), 0);

        // Release coinciding with the long terminal count counts as short
        snap();
        do_press(0, 64, e);
        chk("tie_short", n_short[0] - b_short[0], 1);
        chk("tie_long", n_long[0] - b_long[0], 0);
        snap();
        do_press(0, 65, e);
        chk("over_short", n_short[0] - b_short[0], 0);
        chk("over_long", n_long[0] - b_long[0], 1);
        chk("over_rel", n_rel[0] - b_rel[0], 1);
        chk("k0_long_speed", int'(speed_sel), 1);

        // Simultaneous presses, then reset in the middle of key 1's hold
        snap();
        key_n = 2'b00;
        e = cyc;
        step(30);
        key_n[0] = 1'b1;
        step(30);
        chk("sim_same_cyc", press_cyc[0] - press_cyc[1], 0);
        chk("sim_press_lat", press_cyc[1] - e, 11);
        chk("sim_press1", n_press[1] - b_press[1], 1);
        chk("sim_short0", n_short[0] - b_short[0], 1);
        chk("sim_no_long", n_long[1] - b_long[1], 0);
        chk("sim_speed", int'(speed_sel), 2);
        sys_rst_n = 1'b0;
        #2;
        chk("midrst_level", int'(key_level), 0);
        chk("midrst_speed", int'(speed_sel), 0);
        chk("midrst_pulses", int'({key_press, key_release, key_short, key_long}), 0);
        step(2);
        snap();
        sys_rst_n = 1'b1;
        r = cyc;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1);
            if (n_press[1] != b_press[1]) found = 1'b1;
        end
        chk("post_rst_press_seen", int'(found), 1);
        lat = press_cyc[1] - r;
        chk("post_rst_lat_window", int'(found && lat >= 10 && lat <= 11), 1);
        chk("post_rst_key0_quiet", n_press[0] - b_press[0], 0);
        key_n[1] = 1'b1;
        step(30);
        chk("post_rst_short", n_short[1] - b_short[1], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
